// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant, held until the owner drops req
// or MAX_HOLD cycles elapse, with one dead cycle after every release.
module rr_arbiter #(
    parameter int NUM_AGENTS = 4,
    parameter int MAX_HOLD   = 16,
    parameter int ID_W       = (NUM_AGENTS > 1) ? $clog2(NUM_AGENTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_AGENTS-1:0] req,
    output logic [NUM_AGENTS-1:0] gnt,
    output logic                  gnt_valid,
    output logic [ID_W-1:0]       gnt_id,
    output logic                  preempt
);
    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [HC_W-1:0] hold_cnt;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] next_ptr;
    logic            owner_req;
    logic            hold_expired;

    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_AGENTS-1:0] r,
                                                input logic [ID_W-1:0]       p);
        logic [ID_W-1:0]       sel;
        logic [NUM_AGENTS-1:0] sh;
        logic                  found;
        int                    idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_AGENTS; k++) begin
            idx = (int'(p) + k) % NUM_AGENTS;
            sh  = r >> idx;
            if (!found && sh[0]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] o);
        if (int'(o) == NUM_AGENTS - 1)
            return '0;
        return o + 1'b1;
    endfunction

    // Counter parks at all-ones so an unlimited hold never wraps.
    function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] c);
        if (c == '1)
            return c;
        return c + 1'b1;
    endfunction

    function automatic logic [NUM_AGENTS-1:0] to_onehot(input logic [ID_W-1:0] id);
        return NUM_AGENTS'(1) << id;
    endfunction

    assign pick_id      = rr_pick(req, ptr);
    assign next_ptr     = wrap_inc(gnt_id);
    assign owner_req    = |(req & gnt);
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HC_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= to_onehot(pick_id);
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HC_W'(1);
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Owner still requesting here means the hold limit forced it off.
                    if (!owner_req || hold_expired) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                        hold_cnt  <= '0;
                        ptr       <= next_ptr;
                        preempt   <= owner_req;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= sat_inc(hold_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: one instance with MAX_HOLD=4, one unlimited.
module tb_rr_arbiter;
    typedef struct packed {
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic       pre;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req4 = '0;
    logic [3:0] req0 = '0;
    logic [3:0] gnt4, gnt0;
    logic       gv4, gv0;
    logic [1:0] id4, id0;
    logic       pre4, pre0;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    rr_arbiter #(.NUM_AGENTS(4), .MAX_HOLD(4)) dut4 (
        .clk(clk), .reset(reset), .req(req4),
        .gnt(gnt4), .gnt_valid(gv4), .gnt_id(id4), .preempt(pre4)
    );

    rr_arbiter #(.NUM_AGENTS(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0),
        .gnt(gnt0), .gnt_valid(gv0), .gnt_id(id0), .preempt(pre0)
    );

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] id,
                                input logic v, input logic p);
        exp_t e;
        e.gnt = g;
        e.vld = v;
        e.id  = id;
        e.pre = p;
        return e;
    endfunction

    task automatic do_reset();
        req4  = '0;
        req0  = '0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        req4  = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                reset = 1'b0;
                req4  = '0;
            end
            sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
            @(posedge clk);
            #1 e = sb.pop_front();
            tests_run++;
            if ({gnt4, gv4, id4, pre4} !== e) begin
                tests_failed++;
                $display("FAIL reset_idle cycle %0d: got %b required %b", i, {gnt4, gv4, id4, pre4}, e);
            end
        end
    endtask

    task automatic test_single();
        exp_t e;
        logic [3:0] stim[4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
        sb.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0));
        sb.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0));
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            req4 = stim[i];
            @(posedge clk);
            #1 e = sb.pop_front();
            tests_run++;
            if ({gnt4, gv4, id4, pre4} !== e) begin
                tests_failed++;
                $display("FAIL single_req cycle %0d: got %b required %b", i, {gnt4, gv4, id4, pre4}, e);
            end
        end
    endtask

    task automatic test_forced_rotation();
        exp_t e;
        int   n;
        do_reset();
        req4 = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++)
                sb.push_back(mk(4'b0001 << (g % 4), 2'(g % 4), 1'b1, 1'b0));
            sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b1));
        end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 e = sb.pop_front();
            tests_run++;
            if ({gnt4, gv4, id4, pre4} !== e) begin
                tests_failed++;
                $display("FAIL forced_rotation cycle %0d: got %b required %b", i, {gnt4, gv4, id4, pre4}, e);
            end
        end
        req4 = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_pointer();
        exp_t e;
        logic [3:0] stim[7] = '{4'b0100, 4'b1101, 4'b1001, 4'b1001, 4'b0001, 4'b0001, 4'b0000};
        do_reset();
        sb.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b0));
        sb.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b0));
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        sb.push_back(mk(4'b1000, 2'd3, 1'b1, 1'b0));
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++) begin
            req4 = stim[i];
            @(posedge clk);
            #1 e = sb.pop_front();
            tests_run++;
            if ({gnt4, gv4, id4, pre4} !== e) begin
                tests_failed++;
                $display("FAIL rr_pointer cycle %0d: got %b required %b", i, {gnt4, gv4, id4, pre4}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        req4 = 4'b0100;
        sb.push_back(mk(4'b0100, 2'd2, 1'b1, 1'b0));
        @(posedge clk);
        #1 e = sb.pop_front();
        tests_run++;
        if ({gnt4, gv4, id4, pre4} !== e) begin
            tests_failed++;
            $display("FAIL async_reset_pre got %b required %b", {gnt4, gv4, id4, pre4}, e);
        end
        #2 reset = 1'b1;
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
        #1 e = sb.pop_front();
        tests_run++;
        if ({gnt4, gv4, id4, pre4} !== e) begin
            tests_failed++;
            $display("FAIL async_reset_clear got %b required %b", {gnt4, gv4, id4, pre4}, e);
        end
        req4 = 4'b1111;
        #1 reset = 1'b0;
        sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
        @(posedge clk);
        #1 e = sb.pop_front();
        tests_run++;
        if ({gnt4, gv4, id4, pre4} !== e) begin
            tests_failed++;
            $display("FAIL async_reset_first_grant got %b required %b", {gnt4, gv4, id4, pre4}, e);
        end
        req4 = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unlimited_hold();
        exp_t e;
        do_reset();
        req0 = 4'b0011;
        for (int i = 0; i < 103; i++) begin
            if (i == 100)
                req0 = 4'b0010;
            else if (i == 102)
                req0 = 4'b0000;
            if (i < 100)
                sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0));
            else if (i == 100)
                sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
            else if (i == 101)
                sb.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0));
            else
                sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
            @(posedge clk);
            #1 e = sb.pop_front();
            tests_run++;
            if ({gnt0, gv0, id0, pre0} !== e) begin
                tests_failed++;
                $display("FAIL unlimited_hold cycle %0d: got %b required %b", i, {gnt0, gv0, id0, pre0}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_forced_rotation();
        test_rr_pointer();
        test_async_reset();
        test_unlimited_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Responder (arbiter) end of the per-agent req/gnt arbitration interface.
- Samples one request line per agent and issues a registered one-hot grant using round-robin priority.
- Holds each grant until the owner drops its request or a hold limit expires.
- Drives the gnt side of every agent slice; the testbench and agents drive req.

Parameters:
- NUM_AGENTS, 4, number of requesting agents (>=1).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 = unlimited.
- ID_W, (NUM_AGENTS>1 ? $clog2(NUM_AGENTS) : 1), width of gnt_id.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_AGENTS  request per agent; bit i = agent i.
- gnt  output  NUM_AGENTS  registered one-hot grant; at most one bit set.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  ID_W  registered index of current owner; 0 when gnt_valid=0.
- preempt  output  1  one-cycle registered pulse on a forced (MAX_HOLD) release.

Behaviour:
- Reset (async assert, outputs clear without a clock edge):
  - gnt=0, gnt_valid=0, gnt_id=0, preempt=0.
  - State IDLE, priority pointer ptr=0, hold_cnt=0.
- Reset release: first arbitration at the first rising edge with reset low.
- State IDLE:
  - At an edge with req!=0: choose the first set bit scanning ptr, ptr+1, ... modulo NUM_AGENTS.
  - Set gnt, gnt_id and gnt_valid from that edge, set hold_cnt=1, go to GRANT.
  - Latency: req sampled at edge k gives gnt visible after edge k (one clock).
  - With req==0: remain in IDLE, outputs 0.
- State GRANT (owner o):
  - At each edge, if req[o]==0: release. Clear gnt/gnt_valid/gnt_id, set ptr=(o+1) mod NUM_AGENTS, go to IDLE, preempt=0.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD: forced release. Same clears and ptr update, preempt=1 for exactly the following cycle.
  - Else: keep the grant and increment hold_cnt. Saturate the counter when MAX_HOLD=0; it never wraps.
  - Requests from non-owners are ignored while in GRANT; no mid-grant preemption by priority.
- Dead cycle: every release is followed by exactly one cycle with gnt=0. There is never a back-to-back grant change, so grants to two agents never overlap or abut.
- Fairness: after owner o is released, o has lowest priority. Any continuously requesting agent is granted within NUM_AGENTS grants.
- Grant count: a grant lasts min(cycles req[o] held after grant, MAX_HOLD) cycles. The minimum is 1 cycle if req[o] drops at the first edge after grant.
- Owner re-request: if owner o re-raises req immediately and no other agent requests, o may win again after the dead cycle.
- NUM_AGENTS=1: gnt_id constant 0; otherwise identical behaviour.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1.
- Reset mid-GRANT: immediate clear of all state; ptr returns to 0.

Test Plan:
- Reset/idle (NUM_AGENTS=4, MAX_HOLD=4): hold reset 3 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0, preempt=0. Release with req=0 for 5 cycles -> outputs stay 0.
- Single request: req=4'b0010 sampled at edge k -> gnt=4'b0010, gnt_id=1, gnt_valid=1 after edge k. Drop req before edge k+2 -> gnt=0 after edge k+2, preempt=0.
- Forced rotation: req=4'b1111 held constant, MAX_HOLD=4. Expected sequence:
  - gnt_id 0,1,2,3,0 in turn, each grant exactly 4 cycles.
  - One gnt=0 cycle between consecutive grants.
  - preempt=1 in each of those gap cycles.
- Round-robin pointer: agent 2 owns the grant and releases normally while req=4'b1001 -> next grant is agent 3 (not 0), then agent 0 after agent 3 releases.
- Async reset mid-grant: assert reset between clock edges while gnt=4'b0100 -> gnt and gnt_valid drop immediately. After release with req=4'b1111, first grant goes to agent 0.
- Unlimited hold (MAX_HOLD=0): req=4'b0011 held 100 cycles -> gnt=4'b0001 for all 100 cycles, preempt never asserted. Drop req[0] -> one dead cycle, then gnt=4'b0010.
